// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the unified-memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DBG  = 2'b10
  } own_e;

  localparam int MEM_ARB_AW       = 8;
  localparam int MEM_ARB_DW       = 8;
  localparam int MEM_ARB_MAX_HOLD = 8;
endpackage

// File: rtl/mem_arb_hold_cnt.sv
// Saturating count of consecutive grants held by the current owner.
module mem_arb_hold_cnt #(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic load1,
  input  logic inc,
  output logic at_max
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                                cnt_d = '0;
    else if (load1)                         cnt_d = HW'(1);
    else if (inc && (cnt_q != {HW{1'b1}}))  cnt_d = cnt_q + HW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign at_max = (cnt_q >= HW'(MAX_HOLD));
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between CPU and debug/loader, with burst lock and hold limit.
// Build option: MEM_ARB_RR_EN selects round-robin tie-break instead of CPU priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = MEM_ARB_AW,
  parameter int DW       = MEM_ARB_DW,
  parameter int MAX_HOLD = MEM_ARB_MAX_HOLD
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          dbg_req,
  input  logic          cpu_lock,
  input  logic          dbg_lock,
  input  logic          cpu_we,
  input  logic          dbg_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [DW-1:0] dbg_wdata,
  output logic          cpu_gnt,
  output logic          dbg_gnt,
  output logic          cpu_rvalid,
  output logic          dbg_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_cmd_t;

  own_e     owner_q, owner_d, last_q, last_d, win;
  logic     rv_cpu_q, rv_cpu_d, rv_dbg_q, rv_dbg_d;
  logic     owner_req, owner_lock, other_req, tie_cpu, at_max;
  mem_cmd_t cpu_cmd, dbg_cmd, mem_cmd;

  assign cpu_cmd = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign dbg_cmd = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};

`ifdef MEM_ARB_RR_EN
  assign tie_cpu = (last_q != OWN_CPU);
`else
  logic unused_last;
  assign unused_last = ^last_q;
  assign tie_cpu     = 1'b1;
`endif

  always_comb begin
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    other_req  = 1'b0;
    case (owner_q)
      OWN_CPU: begin owner_req = cpu_req; owner_lock = cpu_lock; other_req = dbg_req; end
      OWN_DBG: begin owner_req = dbg_req; owner_lock = dbg_lock; other_req = cpu_req; end
      default: ;
    endcase

    // A locked owner is only preempted once it has used up its hold budget.
    win = OWN_NONE;
    if (owner_req && owner_lock && (!at_max || !other_req)) win = owner_q;
    else if (cpu_req && dbg_req) win = tie_cpu ? OWN_CPU : OWN_DBG;
    else if (cpu_req)            win = OWN_CPU;
    else if (dbg_req)            win = OWN_DBG;
    if (reset) win = OWN_NONE;

    mem_cmd = '0;
    if (win == OWN_CPU)      mem_cmd = cpu_cmd;
    else if (win == OWN_DBG) mem_cmd = dbg_cmd;

    owner_d  = win;
    last_d   = (win == OWN_NONE) ? last_q : win;
    rv_cpu_d = (win == OWN_CPU) && !cpu_we;
    rv_dbg_d = (win == OWN_DBG) && !dbg_we;
  end

  mem_arb_hold_cnt #(.MAX_HOLD(MAX_HOLD)) u_hold (
    .clk    (clk),
    .reset  (reset),
    .clr    (win == OWN_NONE),
    .load1  ((win != OWN_NONE) && (win != owner_q)),
    .inc    ((win != OWN_NONE) && (win == owner_q)),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      last_q   <= OWN_DBG;
      rv_cpu_q <= 1'b0;
      rv_dbg_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      last_q   <= last_d;
      rv_cpu_q <= rv_cpu_d;
      rv_dbg_q <= rv_dbg_d;
    end
  end

  assign cpu_gnt    = (win == OWN_CPU);
  assign dbg_gnt    = (win == OWN_DBG);
  assign mem_addr   = mem_cmd.addr;
  assign mem_we     = mem_cmd.we;
  assign mem_wdata  = mem_cmd.wdata;
  // A read completing into a reset cycle is dropped.
  assign cpu_rvalid = rv_cpu_q && !reset;
  assign dbg_rvalid = rv_dbg_q && !reset;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_mem_arbiter;
  localparam int AW = 8, DW = 8, MAX_HOLD = 8;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic cpu_req, dbg_req, cpu_lock, dbg_lock, cpu_we, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_we;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .dbg_req(dbg_req), .cpu_lock(cpu_lock), .dbg_lock(dbg_lock),
    .cpu_we(cpu_we), .dbg_we(dbg_we), .cpu_addr(cpu_addr), .dbg_addr(dbg_addr),
    .cpu_wdata(cpu_wdata), .dbg_wdata(dbg_wdata),
    .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt), .cpu_rvalid(cpu_rvalid), .dbg_rvalid(dbg_rvalid),
    .cpu_rdata(cpu_rdata), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous-read memory, plus a bench-side preload port.
  logic [DW-1:0] mem [256];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en)       mem[pl_addr]  <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_lock = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_lock = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic drv_cpu(input logic r, l, w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = r; cpu_lock = l; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drv_dbg(input logic r, l, w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dbg_req = r; dbg_lock = l; dbg_we = w; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    drv_cpu(1, 1, 1, 8'h33, 8'h44);
    drv_dbg(1, 1, 1, 8'h55, 8'h66);
    tick(); tick(); #1;
    n_tests++; if ({cpu_gnt, dbg_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got=%b want=00", {cpu_gnt, dbg_gnt}); end
    n_tests++; if ({mem_we, mem_addr, mem_wdata} !== '0) begin n_fail++; $display("FAIL reset_mem got we=%b a=%h d=%h want 0", mem_we, mem_addr, mem_wdata); end
    n_tests++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got=%b want=00", {cpu_rvalid, dbg_rvalid}); end
    idle();
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_cpu_read();
    preload(8'h05, 8'h3C);
    drv_cpu(1, 0, 0, 8'h05, 8'h00);
    #1;
    n_tests++; if ({cpu_gnt, dbg_gnt} !== 2'b10) begin n_fail++; $display("FAIL cpu_read_gnt got=%b want=10", {cpu_gnt, dbg_gnt}); end
    n_tests++; if ({mem_we, mem_addr} !== {1'b0, 8'h05}) begin n_fail++; $display("FAIL cpu_read_mem got we=%b a=%h want we=0 a=05", mem_we, mem_addr); end
    tick();
    idle(); #1;
    n_tests++; if ({cpu_rvalid, dbg_rvalid} !== 2'b10) begin n_fail++; $display("FAIL cpu_read_rvalid got=%b want=10", {cpu_rvalid, dbg_rvalid}); end
    n_tests++; if (cpu_rdata !== 8'h3C) begin n_fail++; $display("FAIL cpu_read_rdata got=%h want=3c", cpu_rdata); end
    tick();
  endtask

  task automatic test_dbg_write();
    drv_dbg(1, 0, 1, 8'h20, 8'hA5);
    #1;
    n_tests++; if ({cpu_gnt, dbg_gnt} !== 2'b01) begin n_fail++; $display("FAIL dbg_write_gnt got=%b want=01", {cpu_gnt, dbg_gnt}); end
    n_tests++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h20, 8'hA5}) begin n_fail++; $display("FAIL dbg_write_mem got we=%b a=%h d=%h want 1/20/a5", mem_we, mem_addr, mem_wdata); end
    tick();
    idle(); #1;
    n_tests++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin n_fail++; $display("FAIL dbg_write_rvalid got=%b want=00", {cpu_rvalid, dbg_rvalid}); end
    n_tests++; if (mem[8'h20] !== 8'hA5) begin n_fail++; $display("FAIL dbg_write_mem_content got=%h want=a5", mem[8'h20]); end
    tick();
  endtask

  // Entering with last grant = DBG, so the first tie is CPU in either mode.
  task automatic test_tie();
    bit exp_cpu, prev_cpu;
    prev_cpu = 0;
    for (int i = 0; i < 6; i++) begin
      drv_cpu(1, 0, 0, 8'h05, 8'h00);
      drv_dbg(1, 0, 0, 8'h20, 8'h00);
      #1;
      exp_cpu = RR ? (i % 2 == 0) : 1'b1;
      n_tests++; if ({cpu_gnt, dbg_gnt} !== {exp_cpu, !exp_cpu}) begin n_fail++; $display("FAIL tie_gnt cyc=%0d got=%b want=%b", i, {cpu_gnt, dbg_gnt}, {exp_cpu, !exp_cpu}); end
      if (i > 0) begin
        n_tests++; if ({cpu_rvalid, dbg_rvalid} !== {prev_cpu, !prev_cpu}) begin n_fail++; $display("FAIL tie_rvalid cyc=%0d got=%b want=%b", i, {cpu_rvalid, dbg_rvalid}, {prev_cpu, !prev_cpu}); end
      end
      prev_cpu = exp_cpu;
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_lock_burst();
    int dbg_done, cyc;
    bit cpu_pend, exp_dbg, exp_cpu, cpu_read_prev;
    dbg_done = 0; cyc = 0; cpu_pend = 0; cpu_read_prev = 0;
    while (dbg_done < 16 && cyc < 40) begin
      drv_dbg(1, 1, 1, 8'h10 + AW'(dbg_done), 8'hC0 + DW'(dbg_done));
      if (cyc == 1) cpu_pend = 1;
      drv_cpu(cpu_pend, 0, 0, 8'h40, 8'h00);
      #1;
      exp_cpu = (cyc == MAX_HOLD);
      exp_dbg = !exp_cpu;
      n_tests++; if ({cpu_gnt, dbg_gnt} !== {exp_cpu, exp_dbg}) begin n_fail++; $display("FAIL burst_gnt cyc=%0d got=%b want=%b", cyc, {cpu_gnt, dbg_gnt}, {exp_cpu, exp_dbg}); end
      if (exp_dbg) begin
        n_tests++; if (mem_addr !== 8'h10 + AW'(dbg_done)) begin n_fail++; $display("FAIL burst_addr cyc=%0d got=%h want=%h", cyc, mem_addr, 8'h10 + AW'(dbg_done)); end
      end
      n_tests++; if (cpu_rvalid !== cpu_read_prev) begin n_fail++; $display("FAIL burst_cpu_rvalid cyc=%0d got=%b want=%b", cyc, cpu_rvalid, cpu_read_prev); end
      cpu_read_prev = exp_cpu;
      if (dbg_gnt) dbg_done++;
      if (cpu_gnt) cpu_pend = 0;
      cyc++;
      tick();
    end
    n_tests++; if (cyc !== 17) begin n_fail++; $display("FAIL burst_length got=%0d want=17", cyc); end
    idle();
    tick();
  endtask

  task automatic test_lock_no_req();
    drv_dbg(1, 1, 0, 8'h20, 8'h00);
    #1;
    n_tests++; if (dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL lockreq_setup got=%b want=1", dbg_gnt); end
    tick();
    drv_dbg(0, 1, 0, 8'h20, 8'h00);
    #1;
    n_tests++; if ({cpu_gnt, dbg_gnt, mem_we} !== 3'b000) begin n_fail++; $display("FAIL lock_noreq_gnt got=%b want=000", {cpu_gnt, dbg_gnt, mem_we}); end
    tick();
    n_tests++; if (dut.owner_q !== 2'b00) begin n_fail++; $display("FAIL lock_noreq_owner got=%b want=00", dut.owner_q); end
    n_tests++; if (dut.u_hold.cnt_q !== '0) begin n_fail++; $display("FAIL lock_noreq_cnt got=%0d want=0", dut.u_hold.cnt_q); end
    // Ownership was released, so a locked DBG request now loses the tie.
    drv_cpu(1, 0, 0, 8'h05, 8'h00);
    drv_dbg(1, 1, 0, 8'h20, 8'h00);
    #1;
    n_tests++; if ({cpu_gnt, dbg_gnt} !== 2'b10) begin n_fail++; $display("FAIL lock_noreq_release got=%b want=10", {cpu_gnt, dbg_gnt}); end
    idle();
    tick();
    tick();
  endtask

  task automatic test_reset_after_read();
    drv_cpu(1, 0, 0, 8'h05, 8'h00);
    #1;
    n_tests++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_read_gnt got=%b want=1", cpu_gnt); end
    tick();
    reset = 1;
    drv_cpu(1, 0, 0, 8'h05, 8'h00);
    drv_dbg(1, 0, 0, 8'h20, 8'h00);
    #1;
    n_tests++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_read_rvalid got=%b want=0", cpu_rvalid); end
    n_tests++; if ({cpu_gnt, dbg_gnt} !== 2'b00) begin n_fail++; $display("FAIL rst_read_gnt_in_reset got=%b want=00", {cpu_gnt, dbg_gnt}); end
    tick();
    reset = 0;
    #1;
    n_tests++; if ({cpu_gnt, dbg_gnt} !== 2'b10) begin n_fail++; $display("FAIL rst_first_tie got=%b want=10", {cpu_gnt, dbg_gnt}); end
    tick();
    n_tests++; if (cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL rst_first_tie_rvalid got=%b want=1", cpu_rvalid); end
    idle();
    tick();
  endtask

  // Reference model: ownership and hold limit tracked with plain integers.
  task automatic test_random();
    int m_owner, m_cnt, m_last, w;
    bit exp_rv_cpu, exp_rv_dbg, oreq, olock, other;
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] exp_rdata;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic ewe;
    reset = 1; idle();
    tick();
    reset = 0;
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    m_owner = 0; m_cnt = 0; m_last = 2; exp_rv_cpu = 0; exp_rv_dbg = 0; exp_rdata = '0;
    for (int c = 0; c < 1500; c++) begin
      drv_cpu($urandom_range(9, 0) != 0, $urandom_range(9, 0) != 0, $urandom_range(1, 0) == 1,
              AW'($urandom), DW'($urandom));
      drv_dbg($urandom_range(9, 0) != 0, $urandom_range(9, 0) != 0, $urandom_range(1, 0) == 1,
              AW'($urandom), DW'($urandom));
      #1;
      n_tests++; if ({cpu_rvalid, dbg_rvalid} !== {exp_rv_cpu, exp_rv_dbg}) begin n_fail++; $display("FAIL rnd_rvalid cyc=%0d got=%b want=%b", c, {cpu_rvalid, dbg_rvalid}, {exp_rv_cpu, exp_rv_dbg}); end
      if (exp_rv_cpu || exp_rv_dbg) begin
        n_tests++; if ((exp_rv_cpu ? cpu_rdata : dbg_rdata) !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata cyc=%0d got=%h want=%h", c, exp_rv_cpu ? cpu_rdata : dbg_rdata, exp_rdata); end
      end
      oreq  = (m_owner == 1) ? cpu_req  : (m_owner == 2) ? dbg_req  : 1'b0;
      olock = (m_owner == 1) ? cpu_lock : (m_owner == 2) ? dbg_lock : 1'b0;
      other = (m_owner == 1) ? dbg_req  : (m_owner == 2) ? cpu_req  : 1'b0;
      if (oreq && olock && (m_cnt < MAX_HOLD || !other)) w = m_owner;
      else if (cpu_req && dbg_req) w = (RR && m_last == 1) ? 2 : 1;
      else if (cpu_req) w = 1;
      else if (dbg_req) w = 2;
      else w = 0;
      ewe = (w == 1) ? cpu_we    : (w == 2) ? dbg_we    : 1'b0;
      ea  = (w == 1) ? cpu_addr  : (w == 2) ? dbg_addr  : '0;
      ed  = (w == 1) ? cpu_wdata : (w == 2) ? dbg_wdata : '0;
      n_tests++; if ({cpu_gnt, dbg_gnt} !== {w == 1, w == 2}) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%b want=%b", c, {cpu_gnt, dbg_gnt}, {w == 1, w == 2}); end
      n_tests++; if ({mem_we, mem_addr, mem_wdata} !== {ewe, ea, ed}) begin n_fail++; $display("FAIL rnd_mem cyc=%0d got=%b/%h/%h want=%b/%h/%h", c, mem_we, mem_addr, mem_wdata, ewe, ea, ed); end
      exp_rv_cpu = (w == 1) && !ewe;
      exp_rv_dbg = (w == 2) && !ewe;
      exp_rdata  = shadow[ea];
      if (ewe) shadow[ea] = ed;
      if (w != 0) begin
        m_cnt   = (w == m_owner) ? m_cnt + 1 : 1;
        m_owner = w;
        m_last  = w;
      end else begin
        m_owner = 0;
        m_cnt   = 0;
      end
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_cpu_read();
    test_dbg_write();
    test_tie();
    test_lock_burst();
    test_lock_no_req();
    test_reset_after_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
